sample_sector_buffer: RTL and testbench

SAMPLE_SECTOR_BUFFER -- requirements
Module: sample_sector_buffer

---
 rtl/sample_sector_buffer.sv | 183 ++++++++++++++++++
 tb/tb_sample_sector_buffer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_sector_buffer.sv
// Byte ring between a frame-oriented audio port and an SD byte stream.
// Records frames as bytes, padding to a whole sector on stop, or plays bytes back as frames.
`timescale 1ns/1ps
module sample_sector_buffer #(
    parameter int SAMPLE_W = 16,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 2048
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   mode,
    input  logic                         smp_in_valid,
    input  logic [CHANNELS*SAMPLE_W-1:0] smp_in,
    output logic                         smp_in_ready,
    output logic                         wr_byte_valid,
    output logic [7:0]                   wr_byte,
    input  logic                         wr_byte_ready,
    input  logic                         rd_byte_valid,
    input  logic [7:0]                   rd_byte,
    output logic                         rd_byte_ready,
    output logic                         smp_out_valid,
    output logic [CHANNELS*SAMPLE_W-1:0] smp_out,
    input  logic                         smp_out_ready,
    output logic                         sector_avail,
    output logic                         space_avail,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         overrun,
    output logic                         underrun
);

    localparam int FW     = CHANNELS * SAMPLE_W;
    localparam int FB     = FW / 8;
    localparam int SECTOR = 512;
    localparam int AW     = $clog2(DEPTH);
    localparam int LW     = AW + 1;
    localparam int CW     = $clog2(FB + 1);
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0] FB_L     = LW'(FB);
    localparam logic [LW-1:0] SECTOR_L = LW'(SECTOR);

    typedef enum logic [1:0] {IDLE, RECORD, FLUSH, PLAY} state_t;

    state_t          state, state_next;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [FW-1:0]   ser_buf, des_buf;
    logic [CW-1:0]   ser_cnt, des_cnt;
    logic [8:0]      wr_total;
    logic            delivered;
    logic            ser_busy, entering;
    logic            push, pop;
    logic [7:0]      push_data, rd_data;
    logic [FW+7:0]   des_shift;

    assign rd_data      = mem[rd_ptr];
    assign ser_busy     = (ser_cnt != '0);
    assign des_shift    = {rd_data, des_buf};
    assign entering     = (state == IDLE) && (state_next == RECORD || state_next == PLAY);
    assign wr_byte      = wr_byte_valid ? rd_data : 8'h00;
    assign sector_avail = (level >= SECTOR_L);
    assign space_avail  = ((DEPTH_L - level) >= SECTOR_L);

    always_comb begin
        state_next    = state;
        push          = 1'b0;
        pop           = 1'b0;
        push_data     = 8'h00;
        smp_in_ready  = 1'b0;
        wr_byte_valid = 1'b0;
        rd_byte_ready = 1'b0;
        case (state)
            IDLE: begin
                if (mode == 2'b01)      state_next = RECORD;
                else if (mode == 2'b10) state_next = PLAY;
            end
            RECORD: begin
                smp_in_ready  = !ser_busy && ((DEPTH_L - level) >= FB_L);
                wr_byte_valid = (level != '0);
                pop           = wr_byte_valid && wr_byte_ready;
                push          = ser_busy;
                push_data     = ser_buf[7:0];
                if (mode != 2'b01) state_next = FLUSH;
            end
            FLUSH: begin
                // A frame caught mid-serialization finishes before zero padding starts
                wr_byte_valid = (level != '0);
                pop           = wr_byte_valid && wr_byte_ready;
                if (ser_busy) begin
                    push      = 1'b1;
                    push_data = ser_buf[7:0];
                end else if (wr_total != 9'd0 && level < DEPTH_L) begin
                    push      = 1'b1;
                end
                if (!ser_busy && wr_total == 9'd0 && level == '0) state_next = IDLE;
            end
            PLAY: begin
                rd_byte_ready = (level < DEPTH_L);
                push          = rd_byte_valid && rd_byte_ready;
                push_data     = rd_byte;
                pop           = !smp_out_valid && (level != '0);
                if (mode != 2'b10) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            wr_total      <= '0;
            ser_buf       <= '0;
            ser_cnt       <= '0;
            des_buf       <= '0;
            des_cnt       <= '0;
            smp_out       <= '0;
            smp_out_valid <= 1'b0;
            delivered     <= 1'b0;
            overrun       <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            state <= state_next;
            if (entering) begin
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                level         <= '0;
                wr_total      <= '0;
                ser_cnt       <= '0;
                des_cnt       <= '0;
                smp_out_valid <= 1'b0;
                delivered     <= 1'b0;
                overrun       <= 1'b0;
                underrun      <= 1'b0;
            end else if (state_next == IDLE) begin
                // Leaving PLAY (or sitting idle) discards the ring and any partial frame
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                level         <= '0;
                ser_cnt       <= '0;
                des_cnt       <= '0;
                smp_out_valid <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                level <= level + LW'(push) - LW'(pop);
                if (push && state != PLAY) wr_total <= wr_total + 9'd1;

                if (smp_in_valid && smp_in_ready) begin
                    ser_buf <= smp_in;
                    ser_cnt <= CW'(FB);
                end else if (ser_busy) begin
                    ser_buf <= ser_buf >> 8;
                    ser_cnt <= ser_cnt - 1'b1;
                end
                if (state == RECORD && smp_in_valid && !smp_in_ready) overrun <= 1'b1;

                if (state == PLAY) begin
                    if (smp_out_valid && smp_out_ready) begin
                        smp_out_valid <= 1'b0;
                        delivered     <= 1'b1;
                    end else if (pop) begin
                        if (des_cnt == CW'(FB - 1)) begin
                            smp_out       <= des_shift[FW+7:8];
                            smp_out_valid <= 1'b1;
                            des_cnt       <= '0;
                        end else begin
                            des_buf <= des_shift[FW+7:8];
                            des_cnt <= des_cnt + 1'b1;
                        end
                    end
                    if (smp_out_ready && !smp_out_valid && delivered) underrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sample_sector_buffer.sv
// Scoreboard bench for sample_sector_buffer: stimulus queues expected bytes/frames,
// a negedge monitor compares them as the DUT hands them over.
`timescale 1ns/1ps
module tb_sample_sector_buffer;

    localparam int FW = 32;
    localparam int LW = 12;

    logic          clk;
    logic          rst;
    logic [1:0]    mode;
    logic          smp_in_valid;
    logic [FW-1:0] smp_in;
    logic          smp_in_ready;
    logic          wr_byte_valid;
    logic [7:0]    wr_byte;
    logic          wr_byte_ready;
    logic          rd_byte_valid;
    logic [7:0]    rd_byte;
    logic          rd_byte_ready;
    logic          smp_out_valid;
    logic [FW-1:0] smp_out;
    logic          smp_out_ready;
    logic          sector_avail;
    logic          space_avail;
    logic [LW-1:0] level;
    logic          overrun;
    logic          underrun;

    int            checks = 0;
    int            passes = 0;
    logic [7:0]    byte_q[$];
    logic [31:0]   frame_q[$];
    int            max_level = 0;
    bit            stream_on = 1'b0;
    bit            prev_ov = 1'b0;
    logic [LW-1:0] prev_level = '0;

    sample_sector_buffer #(.SAMPLE_W(16), .CHANNELS(2), .DEPTH(2048)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .smp_in_valid(smp_in_valid), .smp_in(smp_in), .smp_in_ready(smp_in_ready),
        .wr_byte_valid(wr_byte_valid), .wr_byte(wr_byte), .wr_byte_ready(wr_byte_ready),
        .rd_byte_valid(rd_byte_valid), .rd_byte(rd_byte), .rd_byte_ready(rd_byte_ready),
        .smp_out_valid(smp_out_valid), .smp_out(smp_out), .smp_out_ready(smp_out_ready),
        .sector_avail(sector_avail), .space_avail(space_avail), .level(level),
        .overrun(overrun), .underrun(underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Record one frame once the DUT is ready, queueing its bytes little-endian, channel 0 first
    task automatic applyStimulus(input logic [31:0] frame);
        int n = 0;
        while (!smp_in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!smp_in_ready) begin
            checkOutput("frame_accept_timeout", 32'(smp_in_ready), 32'd1);
            return;
        end
        smp_in       = frame;
        smp_in_valid = 1'b1;
        for (int b = 0; b < 4; b++) byte_q.push_back(frame[b*8 +: 8]);
        tick();
        smp_in_valid = 1'b0;
    endtask

    task automatic push_rd_byte(input logic [7:0] b);
        int n = 0;
        while (!rd_byte_ready && n < 100) begin
            tick();
            n++;
        end
        if (!rd_byte_ready) begin
            checkOutput("rd_ready_timeout", 32'(rd_byte_ready), 32'd1);
            return;
        end
        rd_byte       = b;
        rd_byte_valid = 1'b1;
        tick();
        rd_byte_valid = 1'b0;
    endtask

    task automatic wait_level(input logic [LW-1:0] target, input int bound);
        int n = 0;
        while (level !== target && n < bound) begin
            tick();
            n++;
        end
        checkOutput("wait_level", 32'(level), 32'(target));
    endtask

    task automatic wait_frames_drained(input int bound);
        int n = 0;
        while (frame_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        checkOutput("frames_drained", 32'(frame_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        byte_q.delete();
        frame_q.delete();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (wr_byte_valid && wr_byte_ready) begin
                if (byte_q.size() == 0) checkOutput("wr_byte_unexpected", 32'(wr_byte), 32'hFFFF_FFFF);
                else checkOutput("wr_byte", 32'(wr_byte), 32'(byte_q.pop_front()));
            end
            if (smp_out_valid && smp_out_ready) begin
                if (frame_q.size() == 0) checkOutput("smp_out_unexpected", smp_out, 32'hFFFF_FFFF);
                else checkOutput("smp_out", smp_out, frame_q.pop_front());
            end
            if (int'(level) > max_level) max_level = int'(level);
            if (prev_ov) checkOutput("overlap_level", 32'(level), 32'(prev_level));
            prev_ov    = stream_on && rd_byte_valid && rd_byte_ready && !smp_out_valid && (level != '0);
            prev_level = level;
        end else begin
            prev_ov = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0; mode = 2'b00;
        smp_in_valid = 1'b0; smp_in = '0;
        wr_byte_ready = 1'b0; rd_byte_valid = 1'b0; rd_byte = '0; smp_out_ready = 1'b0;
        #2;
        checkOutput("rst_smp_in_ready", 32'(smp_in_ready), 32'd0);
        checkOutput("rst_wr_byte_valid", 32'(wr_byte_valid), 32'd0);
        checkOutput("rst_rd_byte_ready", 32'(rd_byte_ready), 32'd0);
        checkOutput("rst_smp_out_valid", 32'(smp_out_valid), 32'd0);
        checkOutput("rst_sector_avail", 32'(sector_avail), 32'd0);
        checkOutput("rst_space_avail", 32'(space_avail), 32'd1);
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_flags", {30'd0, overrun, underrun}, 32'd0);
        checkOutput("rst_wr_byte", 32'(wr_byte), 32'd0);
        checkOutput("rst_smp_out", smp_out, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        $display("[TB] record 128 frames, writer always ready");
        mode = 2'b01; wr_byte_ready = 1'b1; tick();
        max_level = 0;
        for (int i = 0; i < 128; i++)
            applyStimulus({16'hAAAA + 16'(i), 16'h5555 + 16'(i)});
        tick(10);
        wait_level('0, 50);
        checkOutput("rec_max_level_le4", 32'(max_level <= 4), 32'd1);
        checkOutput("rec_overrun", 32'(overrun), 32'd0);
        checkOutput("rec_bytes_left", 32'(byte_q.size()), 32'd0);
        mode = 2'b00; tick(3);
        checkOutput("rec_back_idle", 32'(dut.state), 32'd0);

        $display("[TB] record 3 frames, writer stalled, then flush");
        mode = 2'b01; wr_byte_ready = 1'b0; tick();
        applyStimulus(32'h1122_3344);
        applyStimulus(32'h5566_7788);
        applyStimulus(32'h99AA_BBCC);
        tick(6);
        checkOutput("flush_pre_level", 32'(level), 32'd12);
        checkOutput("flush_pre_sector", 32'(sector_avail), 32'd0);
        mode = 2'b00;
        for (int i = 0; i < 500; i++) byte_q.push_back(8'h00);
        wait_level(12'd512, 700);
        checkOutput("flush_sector_avail", 32'(sector_avail), 32'd1);
        checkOutput("flush_space_avail", 32'(space_avail), 32'd1);
        tick(3);
        checkOutput("flush_pad_stops", 32'(level), 32'd512);
        wr_byte_ready = 1'b1;
        wait_level('0, 700);
        tick(2);
        checkOutput("flush_idle", 32'(dut.state), 32'd0);
        checkOutput("flush_bytes_left", 32'(byte_q.size()), 32'd0);
        wr_byte_ready = 1'b0;

        $display("[TB] record until full, then overrun");
        mode = 2'b01; tick();
        for (int i = 0; i < 512; i++) applyStimulus(32'(i));
        tick(6);
        checkOutput("full_level", 32'(level), 32'd2048);
        checkOutput("full_in_ready", 32'(smp_in_ready), 32'd0);
        checkOutput("full_space_avail", 32'(space_avail), 32'd0);
        checkOutput("full_no_overrun_yet", 32'(overrun), 32'd0);
        smp_in = 32'hCAFE_F00D; smp_in_valid = 1'b1; tick();
        smp_in_valid = 1'b0; tick();
        checkOutput("full_overrun", 32'(overrun), 32'd1);
        checkOutput("full_level_held", 32'(level), 32'd2048);
        mode = 2'b00;
        do_reset();
        checkOutput("full_overrun_cleared", 32'(overrun), 32'd0);

        $display("[TB] play 8 bytes, then underrun");
        mode = 2'b10; smp_out_ready = 1'b0; tick();
        frame_q.push_back(32'h0403_0201);
        frame_q.push_back(32'h0807_0605);
        for (int i = 1; i <= 8; i++) push_rd_byte(8'(i));
        tick(4);
        checkOutput("play_hold_valid", 32'(smp_out_valid), 32'd1);
        checkOutput("play_hold_data", smp_out, 32'h0403_0201);
        checkOutput("play_hold_level", 32'(level), 32'd4);
        checkOutput("play_no_underrun_yet", 32'(underrun), 32'd0);
        smp_out_ready = 1'b1;
        wait_frames_drained(50);
        tick(2);
        checkOutput("play_underrun", 32'(underrun), 32'd1);
        smp_out_ready = 1'b0; mode = 2'b00; tick(2);
        checkOutput("play_exit_valid", 32'(smp_out_valid), 32'd0);
        checkOutput("play_exit_level", 32'(level), 32'd0);

        $display("[TB] play stream across pointer wrap");
        mode = 2'b10; smp_out_ready = 1'b1; tick();
        stream_on = 1'b1; rd_byte_valid = 1'b1;
        for (int n = 0; n < 2100; n++) begin
            rd_byte = 8'(n);
            if (n % 4 == 3) frame_q.push_back({8'(n), 8'(n - 1), 8'(n - 2), 8'(n - 3)});
            tick();
            if (n == 2047) checkOutput("wr_ptr_wrap", 32'(dut.wr_ptr), 32'd0);
        end
        rd_byte_valid = 1'b0; stream_on = 1'b0;
        wait_frames_drained(1000);
        checkOutput("stream_level_empty", 32'(level), 32'd0);
        smp_out_ready = 1'b0; mode = 2'b00; tick(2);

        $display("[TB] async reset mid-frame in record");
        mode = 2'b01; wr_byte_ready = 1'b0; tick();
        applyStimulus(32'hDEAD_BEEF);
        tick();
        checkOutput("midrst_pre_valid", 32'(wr_byte_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_level", 32'(level), 32'd0);
        checkOutput("midrst_wr_byte_valid", 32'(wr_byte_valid), 32'd0);
        checkOutput("midrst_wr_byte", 32'(wr_byte), 32'd0);
        checkOutput("midrst_in_ready", 32'(smp_in_ready), 32'd0);
        checkOutput("midrst_space_avail", 32'(space_avail), 32'd1);
        byte_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
        checkOutput("midrst_reentry_level", 32'(level), 32'd0);
        checkOutput("midrst_reentry_ready", 32'(smp_in_ready), 32'd1);
        mode = 2'b00; tick(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
